// File: rtl/mul_pipe_nxn.sv
// Three-stage pipelined NxN multiplier (signed/unsigned per operation) built from 4x4 nibble products.
// Optional MUL_PIPE_NXN_STATS_EN adds stat_clr/stat_done/stat_stall transfer and stall counters.
module mul_pipe_nxn #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
`ifdef MUL_PIPE_NXN_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        stat_done,
  output logic [31:0]        stat_stall
`endif
);

  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned NP  = NIB * NIB;

  logic en;

  logic             s0_valid;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  logic             s0_signed;
  logic [TAG_W-1:0] s0_tag;

  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [NP-1:0][7:0] prod_c;

  logic               s1_valid;
  logic [NP-1:0][7:0] s1_prod;
  logic               s1_neg;
  logic [TAG_W-1:0]   s1_tag;

  logic [PW-1:0] sum_c;
  logic [PW-1:0] p_c;

  // Whole pipeline advances together; a full output register with no taker freezes it.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid  <= 1'b0;
      s0_a      <= '0;
      s0_b      <= '0;
      s0_signed <= 1'b0;
      s0_tag    <= '0;
    end else if (en) begin
      s0_valid  <= in_valid;
      s0_a      <= in_a;
      s0_b      <= in_b;
      s0_signed <= in_signed;
      s0_tag    <= in_tag;
    end
  end

  // Sign/magnitude split; the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    a_neg_c = s0_signed & s0_a[WIDTH-1];
    b_neg_c = s0_signed & s0_b[WIDTH-1];
    a_mag_c = a_neg_c ? (~s0_a + WIDTH'(1)) : s0_a;
    b_mag_c = b_neg_c ? (~s0_b + WIDTH'(1)) : s0_b;
    prod_c  = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      for (int unsigned j = 0; j < NIB; j++) begin
        prod_c[i*NIB+j] = {4'b0000, a_mag_c[4*i +: 4]} * {4'b0000, b_mag_c[4*j +: 4]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_neg   <= 1'b0;
      s1_tag   <= '0;
    end else if (en) begin
      s1_valid <= s0_valid;
      s1_prod  <= prod_c;
      s1_neg   <= a_neg_c ^ b_neg_c;
      s1_tag   <= s0_tag;
    end
  end

  // Recombine nibble products at their weights, then restore the sign.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      for (int unsigned j = 0; j < NIB; j++) begin
        sum_c = sum_c + (PW'(s1_prod[i*NIB+j]) << (4 * (i + j)));
      end
    end
    p_c = s1_neg ? (~sum_c + PW'(1)) : sum_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_p     <= p_c;
      out_tag   <= s1_tag;
    end
  end

`ifdef MUL_PIPE_NXN_STATS_EN
  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      stat_done  <= '0;
      stat_stall <= '0;
    end else begin
      if (out_valid && out_ready) stat_done <= stat_done + 32'd1;
      if (out_valid && !out_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_pipe_nxn.sv
// Self-checking bench for mul_pipe_nxn: directed vector table, random streams with backpressure,
// mid-flight reset, and a WIDTH=16 instance (with counter checks when MUL_PIPE_NXN_STATS_EN is set).
module tb_mul_pipe_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_p;

  logic        w_in_valid, w_in_ready, w_in_signed, w_out_valid, w_out_ready;
  logic [15:0] w_in_a, w_in_b;
  logic [3:0]  w_in_tag, w_out_tag;
  logic [31:0] w_out_p;

`ifdef MUL_PIPE_NXN_STATS_EN
  logic        n_stat_clr, w_stat_clr;
  logic [31:0] n_stat_done, n_stat_stall, w_stat_done, w_stat_stall;
`endif

  mul_pipe_nxn #(.WIDTH(8), .TAG_W(4)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
`ifdef MUL_PIPE_NXN_STATS_EN
    , .stat_clr(n_stat_clr), .stat_done(n_stat_done), .stat_stall(n_stat_stall)
`endif
  );

  mul_pipe_nxn #(.WIDTH(16), .TAG_W(4)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
    .in_signed(w_in_signed), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_p(w_out_p), .out_tag(w_out_tag)
`ifdef MUL_PIPE_NXN_STATS_EN
    , .stat_clr(w_stat_clr), .stat_done(w_stat_done), .stat_stall(w_stat_stall)
`endif
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          s;
    logic [15:0] p;
  } vec_t;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_p;
  logic [3:0]  prev_tag;
  logic [3:0]  tag_ctr = 4'd0;
  exp_t        sb[$];
  vec_t        vt[10];

  logic [31:0] w_p_last;
  logic [3:0]  w_tag_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Exact product from plain integer arithmetic, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input bit s, input int w);
    longint x, y;
    logic [63:0] mask;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(x * y) & mask;
  endfunction

  // One cycle on the 8-bit instance: drive at negedge, observe, predict transfers at the next posedge.
  task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b, input bit s,
                      input logic [3:0] tag, input logic [15:0] ep, input bit rdy, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_signed = s; in_tag = tag; out_ready = rdy;
    #1;
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_p", 64'(out_p), 64'(prev_p));
      chk("hold_tag", 64'(out_tag), 64'(prev_tag));
    end
    chk("in_ready", 64'(in_ready), 64'(!out_valid || rdy));
    acc = v && in_ready;
    if (acc) sb.push_back('{p: ep, tag: tag, cyc: cyc});
    if (out_valid && rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got p=0x%0h tag=0x%0h, expected no output", out_p, out_tag);
      end else begin
        e = sb.pop_front();
        chk("out_p", 64'(out_p), 64'(e.p));
        chk("out_tag", 64'(out_tag), 64'(e.tag));
        if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd3);
      end
    end
    prev_stall = out_valid && !rdy;
    prev_p = out_p;
    prev_tag = out_tag;
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 20 && sb.size() > 0; t++) step(1'b0, 8'h0, 8'h0, 1'b0, 4'h0, 16'h0, 1'b1, acc);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // mode 0: always ready; 1: ready low for 5 cycles mid-burst; 2: random ready.
  task automatic stream(input int n, input int mode);
    logic [7:0] a, b;
    bit s, acc, rdy;
    int sent;
    sent = 0;
    a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
    for (int t = 0; t < 400 && sent < n; t++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(t >= 6 && t < 11);
        default: rdy = 1'($urandom);
      endcase
      step(1'b1, a, b, s, tag_ctr, 16'(ref_mul(64'(a), 64'(b), s, 8)), rdy, acc);
      if (mode == 0) chk("stream_accept", 64'(acc), 64'd1);
      if (acc) begin
        sent++;
        tag_ctr++;
        a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      end
    end
    drain();
    chk("stream_sent", 64'(sent), 64'(n));
  endtask

  task automatic w_cyc(input bit v, input logic [15:0] a, input logic [15:0] b, input bit s,
                       input logic [3:0] tag, input bit rdy, output bit acc, output bit xfer);
    @(negedge clk);
    w_in_valid = v; w_in_a = a; w_in_b = b; w_in_signed = s; w_in_tag = tag; w_out_ready = rdy;
    #1;
    acc = v && w_in_ready;
    xfer = w_out_valid && rdy;
    if (xfer) begin
      w_p_last = w_out_p;
      w_tag_last = w_out_tag;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic w_send(input logic [15:0] a, input logic [15:0] b, input bit s,
                        input logic [3:0] tag, input logic [31:0] ep);
    bit acc, xfer;
    int waited;
    w_cyc(1'b1, a, b, s, tag, 1'b1, acc, xfer);
    chk("w_accept", 64'(acc), 64'd1);
    xfer = 1'b0;
    waited = 0;
    while (!xfer && waited < 10) begin
      w_cyc(1'b0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1, acc, xfer);
      waited++;
    end
    chk("w_done", 64'(xfer), 64'd1);
    chk("w_latency", 64'(waited), 64'd3);
    chk("w_p", 64'(w_p_last), 64'(ep));
    chk("w_tag", 64'(w_tag_last), 64'(tag));
  endtask

  initial begin
    bit acc, xfer;
    vt[0] = '{a: 8'hFF, b: 8'hFF, s: 1'b0, p: 16'hFE01};
    vt[1] = '{a: 8'hFF, b: 8'hFF, s: 1'b1, p: 16'h0001};
    vt[2] = '{a: 8'h80, b: 8'h7F, s: 1'b1, p: 16'hC080};
    vt[3] = '{a: 8'h80, b: 8'h80, s: 1'b1, p: 16'h4000};
    vt[4] = '{a: 8'h80, b: 8'h80, s: 1'b0, p: 16'h4000};
    vt[5] = '{a: 8'h12, b: 8'h34, s: 1'b0, p: 16'h03A8};
    vt[6] = '{a: 8'h7F, b: 8'h7F, s: 1'b1, p: 16'h3F01};
    vt[7] = '{a: 8'h80, b: 8'hFF, s: 1'b1, p: 16'h0080};
    vt[8] = '{a: 8'h00, b: 8'h80, s: 1'b1, p: 16'h0000};
    vt[9] = '{a: 8'hFE, b: 8'h03, s: 1'b1, p: 16'hFFFA};

    in_valid = 0; in_a = 0; in_b = 0; in_signed = 0; in_tag = 0; out_ready = 1;
    w_in_valid = 0; w_in_a = 0; w_in_b = 0; w_in_signed = 0; w_in_tag = 0; w_out_ready = 1;
`ifdef MUL_PIPE_NXN_STATS_EN
    n_stat_clr = 0; w_stat_clr = 0;
`endif
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_p", 64'(out_p), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_w_out_valid", 64'(w_out_valid), 64'd0);
    rst_n = 1;

    lat_chk = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, vt[k].a, vt[k].b, vt[k].s, 4'(k + 3), vt[k].p, 1'b1, acc);
      chk("table_accept", 64'(acc), 64'd1);
      drain();
    end

    stream(16, 0);
    lat_chk = 1'b0;
    stream(20, 1);
    stream(40, 2);

    // Three operations in flight, then a single reset edge discards them all.
    for (int k = 0; k < 3; k++) step(1'b1, 8'hA5, 8'h5A, 1'b0, 4'(k), 16'h3A02, 1'b1, acc);
    @(negedge clk);
    rst_n = 0; in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_p", 64'(out_p), 64'd0);
    sb.delete();
    prev_stall = 1'b0;
    for (int t = 0; t < 8; t++) step(1'b0, 8'h0, 8'h0, 1'b0, 4'h0, 16'h0, 1'b1, acc);
    chk("midrst_quiet", 64'(out_valid), 64'd0);

    w_send(16'h8000, 16'h8000, 1'b1, 4'h9, 32'h4000_0000);
    w_send(16'hFFFF, 16'hFFFF, 1'b0, 4'h3, 32'hFFFE_0001);
    w_send(16'hFFFF, 16'h0002, 1'b1, 4'h5, 32'hFFFF_FFFE);
    w_send(16'h1234, 16'h5678, 1'b0, 4'hC, 32'(ref_mul(64'h1234, 64'h5678, 1'b0, 16)));

`ifdef MUL_PIPE_NXN_STATS_EN
    begin
      int sent, got, stalls;
      bit rdy;
      @(negedge clk);
      w_stat_clr = 1;
      @(posedge clk);
      #1;
      w_stat_clr = 0;
      chk("stat_clr_done0", 64'(w_stat_done), 64'd0);
      chk("stat_clr_stall0", 64'(w_stat_stall), 64'd0);
      sent = 0; got = 0; stalls = 0;
      for (int t = 0; t < 100 && got < 10; t++) begin
        rdy = !(got == 3 && stalls < 4 && w_out_valid);
        if (!rdy) stalls++;
        w_cyc(sent < 10, 16'(sent * 37), 16'(sent + 5), 1'b0, 4'(sent), rdy, acc, xfer);
        if (acc) sent++;
        if (xfer) got++;
      end
      chk("stat_got", 64'(got), 64'd10);
      chk("stat_done", 64'(w_stat_done), 64'd10);
      chk("stat_stall", 64'(w_stat_stall), 64'd4);
      @(negedge clk);
      w_stat_clr = 1;
      @(posedge clk);
      #1;
      w_stat_clr = 0;
      chk("stat_done_clr", 64'(w_stat_done), 64'd0);
      chk("stat_stall_clr", 64'(w_stat_stall), 64'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
